execute_pipe: RTL and testbench
===============================

# execute_pipe

Parametrised pipelined Y86 execute stage with registered condition codes and a valid/ready handshake. Sits between the decode and memory stages of the pipelined core. Computes valE, evaluates cmovXX/jXX conditions against the architectural CC register, updates CC on OPq, and holds results in a one-entry E/M output register.

## Interface
- WIDTH, 64: datapath width in bits; must be a multiple of 8, minimum 16.
- STEP, WIDTH/8: stack pointer increment for call/ret/pushq/popq.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low; one clock.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  stage accepts this cycle; equals !out_valid || out_ready.
- in_icode, in_ifun  in  4 each  instruction code and function.
- in_valA, in_valB, in_valC  in  WIDTH each  operands.
- in_dstE, in_dstM  in  4 each  destination register IDs; 4'hF means none.
- cc_suppress  in  1  a later stage holds an exception; block CC writes.
- flush  in  1  squash the held result and the offered instruction.
- out_valid  out  1  E/M register holds a result.
- out_ready  in  1  memory stage consumes.
- out_icode  out  4; out_valE, out_valA  out  WIDTH; out_dstE, out_dstM  out  4; out_cnd  out  1; out_err  out  1 (illegal ifun).
- cc_zf, cc_sf, cc_of  out  1 each  architectural CC register.

## Operation
- Transfer: accept when in_valid && in_ready && !flush. Output consumed when out_valid && out_ready.
- valE by icode:
  - rrmovq/cmovXX (2): valA + 0.
  - irmovq (3): valC + 0.
  - rmmovq/mrmovq (4/5): valB + valC.
  - OPq (6): ifun 0 gives valB+valA; ifun 1 gives valB−valA; ifun 2 gives valB&valA; ifun 3 gives valB^valA.
  - call/pushq (8/A): valB − STEP.
  - ret/popq (9/B): valB + STEP.
  - Any other icode: valE = 0.
- All arithmetic is modulo 2^WIDTH. No carry out.
- Conditions use the current CC register, i.e. the value before any update from this instruction:
  - ifun 0 (always): 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): !ZF.
  - ifun 5 (ge): !(SF^OF).
  - ifun 6 (g): !(SF^OF)&!ZF.
  - ifun 7–F: cnd = 0 and out_err = 1.
- out_cnd is the condition result for icode 2 and 7, and 0 for all other icodes.
- cmovXX with cnd = 0: out_dstE is forced to 4'hF.
- OPq with ifun > 3: valE = 0, out_err = 1, CC unchanged.
- CC update happens on an accepted OPq with legal ifun and !cc_suppress:
  - ZF = (valE == 0).
  - SF = valE[WIDTH-1].
  - OF for add: sign(A) == sign(B) && sign(E) != sign(A).
  - OF for sub: sign(B) != sign(A) && sign(E) != sign(B).
  - OF for and/xor: 0.
- Pass-through: out_valA = in_valA; out_dstM = in_dstM; out_icode = in_icode.
- Flush:
  - out_valid clears at the next edge.
  - The offered instruction is not accepted.
  - CC is not written that cycle.
  - Flush has priority over out_ready and in_valid.

## Timing
- Latency: one cycle from acceptance to out_valid.
- Full throughput when out_ready is held at 1.
- Back-to-back OPq: the second instruction sees the CC written by the first.
- Same-cycle consume and accept is allowed (in_ready = 1 while out_ready = 1).
- Stall (out_valid && !out_ready): all out_* hold, in_ready = 0, CC holds.
- Reset values:
  - out_valid = 0 and all out_* data = 0.
  - out_dstE and out_dstM = 4'hF.
  - ZF = 1, SF = 0, OF = 0.
- Reset mid-transfer discards the held result.

## Configuration
- EXECUTE_IADDQ_EN defined: icode C (iaddq) is legal.
  - valE = valB + valC.
  - CC is updated with add OF rules, under the same suppression rules as OPq.
- Not defined: icode C is treated as an unknown icode (valE = 0, out_err = 0, CC unchanged).

## Structure
- Shared package y86_pkg holds:
  - icode constants (I_NOP..I_IADDQ);
  - ALU op constants (ALU_ADD/SUB/AND/XOR);
  - condition constants (C_YES..C_G);
  - REG_NONE = 4'hF;
  - a cc_t struct {zf, sf, of}.
- One sub-module, alu_flags: combinational WIDTH-parametrised ALU producing result, zf, sf, of.
- The condition evaluator, CC register and E/M register live in the top.

## Test plan
- Reset:
  - Check cc = {Z=1, S=0, O=0}, out_valid = 0, out_dstE = F.
  - Then jle (7/1): expect out_cnd = 1.
- OPq sub, valB = 0x8000_0000_0000_0000, valA = 1:
  - Expect valE = 0x7FFF_FFFF_FFFF_FFFF, Z=0, S=0, O=1.
  - Following jl: expect out_cnd = 1.
- cmovg after addq 5+(-5):
  - Expect valE = 0, Z=1, then cnd = 0 and out_dstE = F.
- Backpressure:
  - Hold out_ready = 0 for 3 cycles with in_valid = 1.
  - Expect in_ready = 0 and outputs stable.
  - Release; expect each instruction to appear exactly once, in order.
- Flush and suppression:
  - Flush on a cycle offering addq: no CC change, out_valid = 0 next cycle.
  - cc_suppress = 1 on xorq: CC unchanged.
- WIDTH=16:
  - pushq with valB = 0x0010: expect valE = 0x000E.
  - popq with valB = 0xFFFE: expect valE = 0x0000.
  - With EXECUTE_IADDQ_EN, iaddq valB = 0x7FFF, valC = 1: expect valE = 0x8000, O=1.

Source files
------------

// File: rtl/y86_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | y86_pkg                                                              |
// | Shared Y86 encodings: icodes, ALU ops, condition codes, CC struct.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] I_IADDQ  = 4'hC;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    localparam logic [3:0] C_YES = 4'd0;
    localparam logic [3:0] C_LE  = 4'd1;
    localparam logic [3:0] C_L   = 4'd2;
    localparam logic [3:0] C_E   = 4'd3;
    localparam logic [3:0] C_NE  = 4'd4;
    localparam logic [3:0] C_GE  = 4'd5;
    localparam logic [3:0] C_G   = 4'd6;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

endpackage
`default_nettype wire

// File: rtl/execute_pipe_alu_flags.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_flags                                                            |
// | Combinational WIDTH-bit ALU computing b OP a plus Z/S/O flags.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_flags
    import y86_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zf,
    output logic             o_sf,
    output logic             o_of
);

    always_comb begin
        o_result = '0;
        o_of     = 1'b0;
        case (i_op)
            ALU_ADD: begin
                o_result = i_b + i_a;
                o_of     = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (o_result[WIDTH-1] != i_a[WIDTH-1]);
            end
            ALU_SUB: begin
                o_result = i_b - i_a;
                o_of     = (i_b[WIDTH-1] != i_a[WIDTH-1]) && (o_result[WIDTH-1] != i_b[WIDTH-1]);
            end
            ALU_AND: o_result = i_b & i_a;
            default: o_result = i_b ^ i_a;
        endcase
        o_zf = (o_result == '0);
        o_sf = o_result[WIDTH-1];
    end

endmodule
`default_nettype wire

// File: rtl/execute_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | execute_pipe                                                         |
// | Y86 execute stage: valE, cond eval, CC register, E/M output register.|
// | Optional: EXECUTE_IADDQ_EN enables iaddq (icode C).                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module execute_pipe
    import y86_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int STEP  = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_icode,
    input  logic [3:0]       in_ifun,
    input  logic [WIDTH-1:0] in_valA,
    input  logic [WIDTH-1:0] in_valB,
    input  logic [WIDTH-1:0] in_valC,
    input  logic [3:0]       in_dstE,
    input  logic [3:0]       in_dstM,
    input  logic             cc_suppress,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_icode,
    output logic [WIDTH-1:0] out_valE,
    output logic [WIDTH-1:0] out_valA,
    output logic [3:0]       out_dstE,
    output logic [3:0]       out_dstM,
    output logic             out_cnd,
    output logic             out_err,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] w_alu_a, w_alu_b, w_alu_res;
    logic [1:0]       w_alu_op;
    logic             w_alu_zf, w_alu_sf, w_alu_of;
    logic             w_use_alu, w_op_err, w_cc_write;
    logic             w_cond, w_cond_ok, w_is_cond, w_cnd, w_accept;
    logic [WIDTH-1:0] w_val_e;
    logic [3:0]       w_dst_e;

    logic             out_valid_q, out_valid_d;
    logic [3:0]       out_icode_q, out_icode_d;
    logic [WIDTH-1:0] out_valE_q, out_valE_d;
    logic [WIDTH-1:0] out_valA_q, out_valA_d;
    logic [3:0]       out_dstE_q, out_dstE_d;
    logic [3:0]       out_dstM_q, out_dstM_d;
    logic             out_cnd_q, out_cnd_d;
    logic             out_err_q, out_err_d;
    cc_t              cc_q, cc_d;

    // Operand steering: every valE goes through the ALU as b OP a.
    always_comb begin
        w_alu_a    = in_valA;
        w_alu_b    = '0;
        w_alu_op   = ALU_ADD;
        w_use_alu  = 1'b1;
        w_op_err   = 1'b0;
        w_cc_write = 1'b0;
        case (in_icode)
            I_RRMOVQ: ;
            I_IRMOVQ: w_alu_a = in_valC;
            I_RMMOVQ, I_MRMOVQ: begin
                w_alu_a = in_valC;
                w_alu_b = in_valB;
            end
            I_OPQ: begin
                if (in_ifun <= 4'd3) begin
                    w_alu_b    = in_valB;
                    w_alu_op   = in_ifun[1:0];
                    w_cc_write = 1'b1;
                end else begin
                    w_use_alu = 1'b0;
                    w_op_err  = 1'b1;
                end
            end
            I_CALL, I_PUSHQ: begin
                w_alu_a  = STEP_W;
                w_alu_b  = in_valB;
                w_alu_op = ALU_SUB;
            end
            I_RET, I_POPQ: begin
                w_alu_a = STEP_W;
                w_alu_b = in_valB;
            end
`ifdef EXECUTE_IADDQ_EN
            I_IADDQ: begin
                w_alu_a    = in_valC;
                w_alu_b    = in_valB;
                w_cc_write = 1'b1;
            end
`endif
            default: w_use_alu = 1'b0;
        endcase
    end

    alu_flags #(.WIDTH(WIDTH)) u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_op     (w_alu_op),
        .o_result (w_alu_res),
        .o_zf     (w_alu_zf),
        .o_sf     (w_alu_sf),
        .o_of     (w_alu_of)
    );

    // Conditions read the CC register as it stands, before this instruction.
    always_comb begin
        w_cond    = 1'b0;
        w_cond_ok = 1'b1;
        case (in_ifun)
            C_YES:   w_cond = 1'b1;
            C_LE:    w_cond = (cc_q.sf ^ cc_q.of) | cc_q.zf;
            C_L:     w_cond = cc_q.sf ^ cc_q.of;
            C_E:     w_cond = cc_q.zf;
            C_NE:    w_cond = !cc_q.zf;
            C_GE:    w_cond = !(cc_q.sf ^ cc_q.of);
            C_G:     w_cond = !(cc_q.sf ^ cc_q.of) && !cc_q.zf;
            default: w_cond_ok = 1'b0;
        endcase
    end

    assign w_is_cond = (in_icode == I_RRMOVQ) || (in_icode == I_JXX);
    assign w_cnd     = w_is_cond && w_cond;
    assign w_val_e   = w_use_alu ? w_alu_res : '0;
    assign w_dst_e   = ((in_icode == I_RRMOVQ) && !w_cnd) ? REG_NONE : in_dstE;
    assign in_ready  = !out_valid_q || out_ready;
    assign w_accept  = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        out_icode_d = out_icode_q;
        out_valE_d  = out_valE_q;
        out_valA_d  = out_valA_q;
        out_dstE_d  = out_dstE_q;
        out_dstM_d  = out_dstM_q;
        out_cnd_d   = out_cnd_q;
        out_err_d   = out_err_q;
        cc_d        = cc_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (w_accept) begin
            out_valid_d = 1'b1;
            out_icode_d = in_icode;
            out_valE_d  = w_val_e;
            out_valA_d  = in_valA;
            out_dstE_d  = w_dst_e;
            out_dstM_d  = in_dstM;
            out_cnd_d   = w_cnd;
            out_err_d   = w_op_err || (w_is_cond && !w_cond_ok);
            if (w_cc_write && !cc_suppress) begin
                cc_d = '{zf: w_alu_zf, sf: w_alu_sf, of: w_alu_of};
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_icode_q <= 4'h0;
            out_valE_q  <= '0;
            out_valA_q  <= '0;
            out_dstE_q  <= REG_NONE;
            out_dstM_q  <= REG_NONE;
            out_cnd_q   <= 1'b0;
            out_err_q   <= 1'b0;
            cc_q        <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
        end else begin
            out_valid_q <= out_valid_d;
            out_icode_q <= out_icode_d;
            out_valE_q  <= out_valE_d;
            out_valA_q  <= out_valA_d;
            out_dstE_q  <= out_dstE_d;
            out_dstM_q  <= out_dstM_d;
            out_cnd_q   <= out_cnd_d;
            out_err_q   <= out_err_d;
            cc_q        <= cc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_icode = out_icode_q;
    assign out_valE  = out_valE_q;
    assign out_valA  = out_valA_q;
    assign out_dstE  = out_dstE_q;
    assign out_dstM  = out_dstM_q;
    assign out_cnd   = out_cnd_q;
    assign out_err   = out_err_q;
    assign cc_zf     = cc_q.zf;
    assign cc_sf     = cc_q.sf;
    assign cc_of     = cc_q.of;

endmodule
`default_nettype wire

// File: tb/tb_execute_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_execute_pipe                                                      |
// | Directed bench for execute_pipe at WIDTH=64 and WIDTH=16.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_execute_pipe;
    import y86_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        in_valid, in_ready, cc_suppress, flush, out_valid, out_ready;
    logic [3:0]  in_icode, in_ifun, in_dstE, in_dstM;
    logic [63:0] in_valA, in_valB, in_valC, out_valE, out_valA;
    logic [3:0]  out_icode, out_dstE, out_dstM;
    logic        out_cnd, out_err, cc_zf, cc_sf, cc_of;

    logic        s_in_valid, s_in_ready, s_out_valid;
    logic [3:0]  s_in_icode, s_in_ifun;
    logic [15:0] s_in_valA, s_in_valB, s_in_valC, s_out_valE, s_out_valA;
    logic [3:0]  s_out_icode, s_out_dstE, s_out_dstM;
    logic        s_out_cnd, s_out_err, s_cc_zf, s_cc_sf, s_cc_of;

    execute_pipe #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_ifun(in_ifun), .in_valA(in_valA), .in_valB(in_valB),
        .in_valC(in_valC), .in_dstE(in_dstE), .in_dstM(in_dstM), .cc_suppress(cc_suppress),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
        .out_valE(out_valE), .out_valA(out_valA), .out_dstE(out_dstE), .out_dstM(out_dstM),
        .out_cnd(out_cnd), .out_err(out_err), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    execute_pipe #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_icode(s_in_icode), .in_ifun(s_in_ifun), .in_valA(s_in_valA), .in_valB(s_in_valB),
        .in_valC(s_in_valC), .in_dstE(4'h1), .in_dstM(REG_NONE), .cc_suppress(1'b0),
        .flush(1'b0), .out_valid(s_out_valid), .out_ready(1'b1), .out_icode(s_out_icode),
        .out_valE(s_out_valE), .out_valA(s_out_valA), .out_dstE(s_out_dstE), .out_dstM(s_out_dstM),
        .out_cnd(s_out_cnd), .out_err(s_out_err), .cc_zf(s_cc_zf), .cc_sf(s_cc_sf), .cc_of(s_cc_of)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] c, input logic [3:0] de,
                         input logic [3:0] dm);
        in_icode = ic; in_ifun = fn; in_valA = a; in_valB = b; in_valC = c;
        in_dstE = de; in_dstM = dm; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic issue16(input logic [3:0] ic, input logic [3:0] fn, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] c);
        s_in_icode = ic; s_in_ifun = fn; s_in_valA = a; s_in_valB = b; s_in_valC = c;
        s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
    endtask

    // Consumption log: inputs are stable from negedge to the next posedge.
    logic [63:0] log_q[$];
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) log_q.push_back(out_valE);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic exp_z;
        int   base;
        rst_n = 1'b0; in_valid = 1'b0; cc_suppress = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_icode = 4'h0; in_ifun = 4'h0; in_valA = '0; in_valB = '0; in_valC = '0;
        in_dstE = REG_NONE; in_dstM = REG_NONE;
        s_in_valid = 1'b0; s_in_icode = 4'h0; s_in_ifun = 4'h0;
        s_in_valA = '0; s_in_valB = '0; s_in_valC = '0;
        repeat (3) tick();

        chk("rst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_dstE", {60'd0, out_dstE}, 64'hF);
        chk("rst_dstM", {60'd0, out_dstM}, 64'hF);
        chk("rst_valE", out_valE, 64'd0);
        chk("rst16_dstE", {60'd0, s_out_dstE}, 64'hF);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        issue(I_JXX, C_LE, 64'd0, 64'd0, 64'h400, REG_NONE, REG_NONE);
        chk("jle_valid", {63'd0, out_valid}, 64'd1);
        chk("jle_cnd", {63'd0, out_cnd}, 64'd1);

        issue(I_OPQ, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h2, REG_NONE);
        chk("subq_valE", out_valE, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("subq_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b001);
        chk("subq_cnd", {63'd0, out_cnd}, 64'd0);

        issue(I_JXX, C_L, 64'd0, 64'd0, 64'h0, REG_NONE, REG_NONE);
        chk("jl_cnd", {63'd0, out_cnd}, 64'd1);

        issue(I_OPQ, 4'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 4'h3, REG_NONE);
        chk("addq_valE", out_valE, 64'd0);
        chk("addq_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);

        issue(I_RRMOVQ, C_G, 64'h1234, 64'd0, 64'd0, 4'h3, 4'h7);
        chk("cmovg_cnd", {63'd0, out_cnd}, 64'd0);
        chk("cmovg_dstE", {60'd0, out_dstE}, 64'hF);
        chk("cmovg_valE", out_valE, 64'h1234);
        chk("cmovg_valA", out_valA, 64'h1234);
        chk("cmovg_dstM", {60'd0, out_dstM}, 64'h7);
        chk("cmovg_icode", {60'd0, out_icode}, 64'h2);

        issue(I_RRMOVQ, C_E, 64'h99, 64'd0, 64'd0, 4'h4, REG_NONE);
        chk("cmove_dstE", {60'd0, out_dstE}, 64'h4);
        chk("cmove_cnd", {63'd0, out_cnd}, 64'd1);

        issue(I_OPQ, 4'd4, 64'd3, 64'd9, 64'd0, 4'h1, REG_NONE);
        chk("opq_bad_valE", out_valE, 64'd0);
        chk("opq_bad_err", {63'd0, out_err}, 64'd1);
        chk("opq_bad_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);

        issue(I_JXX, 4'd8, 64'd0, 64'd0, 64'd0, REG_NONE, REG_NONE);
        chk("jxx_bad_cnd", {63'd0, out_cnd}, 64'd0);
        chk("jxx_bad_err", {63'd0, out_err}, 64'd1);

        issue(I_PUSHQ, 4'd0, 64'd0, 64'h100, 64'd0, 4'h4, REG_NONE);
        chk("pushq_valE", out_valE, 64'hF8);
        chk("pushq_err", {63'd0, out_err}, 64'd0);
        issue(I_POPQ, 4'd0, 64'd0, 64'h100, 64'd0, 4'h4, 4'h5);
        chk("popq_valE", out_valE, 64'h108);
        issue(I_RMMOVQ, 4'd0, 64'h77, 64'h40, 64'h8, REG_NONE, REG_NONE);
        chk("rmmovq_valE", out_valE, 64'h48);
        issue(I_NOP, 4'd0, 64'h5, 64'h6, 64'h7, REG_NONE, REG_NONE);
        chk("nop_valE", out_valE, 64'd0);

        flush = 1'b1;
        issue(I_OPQ, 4'd0, 64'd1, 64'd1, 64'd0, 4'h1, REG_NONE);
        flush = 1'b0;
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);

        cc_suppress = 1'b1;
        issue(I_OPQ, 4'd3, 64'h0F, 64'hF0, 64'd0, 4'h1, REG_NONE);
        cc_suppress = 1'b0;
        chk("xorq_valE", out_valE, 64'hFF);
        chk("xorq_supp_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);

        issue(I_OPQ, 4'd2, 64'hFF00, 64'hF0F0, 64'd0, 4'h1, REG_NONE);
        chk("andq_valE", out_valE, 64'hF000);
        chk("andq_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b000);
        issue(I_JXX, C_E, 64'd0, 64'd0, 64'd0, REG_NONE, REG_NONE);
        chk("je_cnd", {63'd0, out_cnd}, 64'd0);

        issue(I_IADDQ, 4'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'h2, REG_NONE);
        chk("iaddq64_valE", out_valE, 64'd0);
        chk("iaddq64_err", {63'd0, out_err}, 64'd0);
`ifdef EXECUTE_IADDQ_EN
        exp_z = 1'b1;
`else
        exp_z = 1'b0;
`endif
        chk("iaddq64_cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, exp_z, 2'b00});

        // Backpressure: hold one result while a second instruction waits.
        tick();
        chk("bp_drained", {63'd0, out_valid}, 64'd0);
        base = log_q.size();
        out_ready = 1'b0;
        issue(I_IRMOVQ, 4'd0, 64'd0, 64'd0, 64'h11, 4'h1, REG_NONE);
        in_icode = I_OPQ; in_ifun = 4'd0; in_valA = 64'd1; in_valB = 64'd1;
        in_dstE = 4'h2; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_hold_valE", out_valE, 64'h11);
            chk("bp_hold_cc", {63'd0, cc_zf}, {63'd0, exp_z});
            tick();
        end
        chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_hold_final", out_valE, 64'h11);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_second_valE", out_valE, 64'd2);
        chk("bp_second_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b000);
        tick();
        chk("bp_empty", {63'd0, out_valid}, 64'd0);
        chk("bp_count", 64'(log_q.size() - base), 64'd2);
        if (log_q.size() >= base + 2) begin
            chk("bp_order0", log_q[base], 64'h11);
            chk("bp_order1", log_q[base + 1], 64'd2);
        end

        issue16(I_PUSHQ, 4'd0, 16'd0, 16'h0010, 16'd0);
        chk("w16_pushq", {48'd0, s_out_valE}, 64'h000E);
        issue16(I_POPQ, 4'd0, 16'd0, 16'hFFFE, 16'd0);
        chk("w16_popq", {48'd0, s_out_valE}, 64'h0000);
        issue16(I_IADDQ, 4'd0, 16'd0, 16'h7FFF, 16'd1);
`ifdef EXECUTE_IADDQ_EN
        chk("w16_iaddq_valE", {48'd0, s_out_valE}, 64'h8000);
        chk("w16_iaddq_cc", {61'd0, s_cc_zf, s_cc_sf, s_cc_of}, 64'b011);
`else
        chk("w16_iaddq_valE", {48'd0, s_out_valE}, 64'h0000);
        chk("w16_iaddq_cc", {61'd0, s_cc_zf, s_cc_sf, s_cc_of}, 64'b100);
`endif
        chk("w16_iaddq_err", {63'd0, s_out_err}, 64'd0);

        // Asynchronous reset while a result is held.
        out_ready = 1'b0;
        issue(I_OPQ, 4'd0, 64'd2, 64'd3, 64'd0, 4'h1, REG_NONE);
        chk("rstmid_pre", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_valid", {63'd0, out_valid}, 64'd0);
        chk("rstmid_valE", out_valE, 64'd0);
        chk("rstmid_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
